// File: rtl/memory_arbiter_if.sv
// Fetch-port, data-port and RAM-side signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the datapath/RAM side.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        grant_d;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, grant_d
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, grant_d
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between fetch and data; grant registered, completion in the grant cycle at the earliest.
// Requesters stall on iwait/dwait until RAM reports ACCESS; data wins unless fetch has starved STARVE_MAX times.
module memory_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    memory_arbiter_if.slave  arb
);
    localparam int             CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [1:0]     RS_ACCESS  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_starve_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_dreq;
    logic            w_access;
    logic            w_ram_ren;
    logic            w_ram_wen;
    logic [31:0]     w_ram_addr;
    logic [31:0]     w_ram_store;

    assign w_dreq   = arb.dREN | arb.dWEN;
    assign w_access = (arb.ramstate == RS_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_starve_cnt;
        w_ram_ren   = 1'b0;
        w_ram_wen   = 1'b0;
        w_ram_addr  = '0;
        w_ram_store = '0;
        case (r_state)
            IDLE: begin
                if (!arb.iREN)
                    w_cnt_nxt = '0;
                if (w_dreq && (r_starve_cnt < STARVE_LIM || !arb.iREN))
                    w_state_nxt = DGRANT;
                else if (arb.iREN)
                    w_state_nxt = IGRANT;
            end
            IGRANT: begin
                w_ram_ren  = 1'b1;
                w_ram_addr = arb.iaddr;
                if (w_access) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (!arb.iREN) begin
                    w_state_nxt = IDLE;
                end
            end
            DGRANT: begin
                // A simultaneous read+write request is treated as a write.
                w_ram_ren   = arb.dREN & ~arb.dWEN;
                w_ram_wen   = arb.dWEN;
                w_ram_addr  = arb.daddr;
                w_ram_store = arb.dstore;
                if (w_access) begin
                    w_state_nxt = IDLE;
                    if (!arb.iREN)
                        w_cnt_nxt = '0;
                    else if (r_starve_cnt != STARVE_LIM)
                        w_cnt_nxt = r_starve_cnt + CW'(1);
                end else if (!w_dreq) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign arb.ramREN   = w_ram_ren;
    assign arb.ramWEN   = w_ram_wen;
    assign arb.ramaddr  = w_ram_addr;
    assign arb.ramstore = w_ram_store;
    assign arb.iload    = arb.ramload;
    assign arb.dload    = arb.ramload;
    assign arb.iwait    = arb.iREN & ~((r_state == IGRANT) && w_access);
    assign arb.dwait    = w_dreq & ~((r_state == DGRANT) && w_access);
    assign arb.grant_d  = (r_state == DGRANT);
endmodule
